// File: rtl/noaa_window_stats.sv
// Sliding-window mean / standard deviation over the last DEPTH temperature samples.
// Define NOAA_STDDEV_EN to build the standard-deviation path (Sumsq, DIV_SQ, VAR, SQRT).
module noaa_window_stats #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8,
  localparam int NW    = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] TN,
  input  logic              TN_VALID,
  input  logic              START,
  input  logic              MODE,
  output logic              SAMPLE,
  output logic              DONE,
  output logic [DATA_W-1:0] AVG_SD,
  output logic [NW-1:0]     N
);

  localparam int PW    = $clog2(DEPTH);
  localparam int SUM_W = DATA_W + $clog2(DEPTH);
`ifdef NOAA_STDDEV_EN
  localparam int SQ_W  = 2 * DATA_W + $clog2(DEPTH);
  localparam int VW    = 2 * DATA_W;
  localparam int DVW   = SQ_W;
`else
  localparam int DVW   = SUM_W;
`endif
  localparam int CW    = $clog2(DVW + 1);

  typedef enum logic [2:0] {S_IDLE, S_DIV_MEAN, S_DIV_SQ, S_VAR, S_SQRT, S_FINISH} state_t;
  state_t r_state, w_state_nxt;

  logic [DATA_W-1:0] r_win [DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [NW-1:0]     r_n, w_n_nxt;
  logic [SUM_W-1:0]  r_tsum, w_tsum_nxt;
  logic              r_sample, r_done;
  logic [DATA_W-1:0] r_avg, r_result, w_old;
  logic [DVW-1:0]    r_dvd;
  logic [NW-1:0]     r_rem, w_rem_nxt;
  logic [CW-1:0]     r_cnt;
  logic [NW:0]       w_trial;
  logic              w_acc, w_start, w_full, w_qbit, w_cnt_last;

`ifdef NOAA_STDDEV_EN
  logic              r_mode;
  logic [SQ_W-1:0]   r_sumsq, w_sumsq_nxt;
  logic [VW-1:0]     r_msq, r_x, w_old_sq, w_tn_sq, w_mean_sq;
  logic [DATA_W-1:0] r_mean, r_root, r_srem, w_srem_nxt;
  logic [VW:0]       w_var;
  logic [DATA_W+1:0] w_sq_sh, w_sq_t;
  logic              w_sq_bit;
`else
  logic              w_unused_mode;
  assign w_unused_mode = MODE;
`endif

  // Window update values; a sample accepted with START is part of the snapshot.
  always_comb begin
    w_acc      = r_sample & TN_VALID;
    w_start    = r_sample & START;
    w_full     = (r_n == NW'(DEPTH));
    w_old      = w_full ? r_win[r_wptr] : '0;
    w_cnt_last = (r_cnt == '0);
    if (w_acc) begin
      w_n_nxt    = w_full ? r_n : r_n + NW'(1);
      w_tsum_nxt = r_tsum - SUM_W'(w_old) + SUM_W'(TN);
    end else begin
      w_n_nxt    = r_n;
      w_tsum_nxt = r_tsum;
    end
    // Restoring-divide step; the divisor is N, which is frozen while busy.
    w_trial   = {r_rem, r_dvd[DVW-1]};
    w_qbit    = (w_trial >= {1'b0, r_n});
    w_rem_nxt = w_qbit ? NW'(w_trial - {1'b0, r_n}) : w_trial[NW-1:0];
`ifdef NOAA_STDDEV_EN
    w_old_sq    = {{DATA_W{1'b0}}, w_old} * {{DATA_W{1'b0}}, w_old};
    w_tn_sq     = {{DATA_W{1'b0}}, TN} * {{DATA_W{1'b0}}, TN};
    w_sumsq_nxt = w_acc ? (r_sumsq - SQ_W'(w_old_sq) + SQ_W'(w_tn_sq)) : r_sumsq;
    w_mean_sq   = {{DATA_W{1'b0}}, r_mean} * {{DATA_W{1'b0}}, r_mean};
    w_var       = {1'b0, r_msq} - {1'b0, w_mean_sq};
    w_sq_sh     = {r_srem, r_x[VW-1 -: 2]};
    w_sq_t      = {r_root, 2'b01};
    w_sq_bit    = (w_sq_sh >= w_sq_t);
    w_srem_nxt  = w_sq_bit ? DATA_W'(w_sq_sh - w_sq_t) : w_sq_sh[DATA_W-1:0];
`endif
  end

  // Circular sample window with running sums.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) r_win[i] <= '0;
      r_wptr <= '0;
      r_n    <= '0;
      r_tsum <= '0;
`ifdef NOAA_STDDEV_EN
      r_sumsq <= '0;
`endif
    end else if (w_acc) begin
      r_win[r_wptr] <= TN;
      r_wptr        <= (r_wptr == PW'(DEPTH - 1)) ? '0 : r_wptr + PW'(1);
      r_n           <= w_n_nxt;
      r_tsum        <= w_tsum_nxt;
`ifdef NOAA_STDDEV_EN
      r_sumsq       <= w_sumsq_nxt;
`endif
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) w_state_nxt = (w_n_nxt == '0) ? S_FINISH : S_DIV_MEAN;
        else         w_state_nxt = S_IDLE;
      end
      S_DIV_MEAN: begin
        if (!w_cnt_last) w_state_nxt = S_DIV_MEAN;
`ifdef NOAA_STDDEV_EN
        else if (r_mode) w_state_nxt = S_DIV_SQ;
`endif
        else             w_state_nxt = S_FINISH;
      end
`ifdef NOAA_STDDEV_EN
      S_DIV_SQ: begin
        if (w_cnt_last) w_state_nxt = S_VAR;
        else            w_state_nxt = S_DIV_SQ;
      end
      S_VAR:    w_state_nxt = S_SQRT;
      S_SQRT: begin
        if (w_cnt_last) w_state_nxt = S_FINISH;
        else            w_state_nxt = S_SQRT;
      end
`endif
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Computation datapath: divider, variance clamp and bit-serial square root.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_dvd    <= '0;
      r_rem    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
`ifdef NOAA_STDDEV_EN
      r_mode <= 1'b0;
      r_mean <= '0;
      r_msq  <= '0;
      r_x    <= '0;
      r_srem <= '0;
      r_root <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_dvd    <= DVW'(w_tsum_nxt) << (DVW - SUM_W);
            r_rem    <= '0;
            r_cnt    <= CW'(SUM_W - 1);
            r_result <= '0;
`ifdef NOAA_STDDEV_EN
            r_mode   <= MODE;
`endif
          end
        end
        S_DIV_MEAN: begin
          r_dvd <= {r_dvd[DVW-2:0], w_qbit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_cnt_last) begin
            r_result <= {r_dvd[DATA_W-2:0], w_qbit};
`ifdef NOAA_STDDEV_EN
            r_mean <= {r_dvd[DATA_W-2:0], w_qbit};
            r_dvd  <= r_sumsq;
            r_rem  <= '0;
            r_cnt  <= CW'(SQ_W - 1);
`endif
          end
        end
`ifdef NOAA_STDDEV_EN
        S_DIV_SQ: begin
          r_dvd <= {r_dvd[DVW-2:0], w_qbit};
          r_rem <= w_rem_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (w_cnt_last) r_msq <= {r_dvd[VW-2:0], w_qbit};
        end
        S_VAR: begin
          r_x    <= w_var[VW] ? '0 : w_var[VW-1:0];
          r_srem <= '0;
          r_root <= '0;
          r_cnt  <= CW'(DATA_W - 1);
        end
        S_SQRT: begin
          r_x    <= r_x << 2;
          r_srem <= w_srem_nxt;
          r_root <= {r_root[DATA_W-2:0], w_sq_bit};
          r_cnt  <= r_cnt - CW'(1);
          if (w_cnt_last) r_result <= {r_root[DATA_W-2:0], w_sq_bit};
        end
`endif
        default: ;
      endcase
    end
  end

  // Handshake outputs; SAMPLE stays low through the DONE cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sample <= 1'b0;
      r_done   <= 1'b0;
      r_avg    <= '0;
    end else begin
      r_sample <= (w_state_nxt == S_IDLE) && (r_state != S_FINISH);
      r_done   <= (r_state == S_FINISH);
      if (r_state == S_FINISH) r_avg <= r_result;
    end
  end

  assign SAMPLE = r_sample;
  assign DONE   = r_done;
  assign AVG_SD = r_avg;
  assign N      = r_n;

endmodule

// File: tb/tb_noaa_window_stats.sv
// Directed self-checking bench for noaa_window_stats at default parameters.
module tb_noaa_window_stats;
  localparam int LAT_MEAN = 16;
`ifdef NOAA_STDDEV_EN
  localparam int LAT_SD = 56;
  localparam logic [11:0] EXP_SD = 12'd2;
  localparam int MID = 20;
`else
  localparam int LAT_SD = 16;
  localparam logic [11:0] EXP_SD = 12'd5;
  localparam int MID = 10;
`endif

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic [11:0] TN = 12'd0;
  logic TN_VALID = 1'b0, START = 1'b0, MODE = 1'b0;
  logic SAMPLE, DONE;
  logic [11:0] AVG_SD;
  logic [3:0] N;
  int checks = 0;
  int failures = 0;

  noaa_window_stats dut (
    .CLK(CLK), .RESET(RESET), .TN(TN), .TN_VALID(TN_VALID), .START(START),
    .MODE(MODE), .SAMPLE(SAMPLE), .DONE(DONE), .AVG_SD(AVG_SD), .N(N)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    tick();
  endtask

  task automatic push(input logic [11:0] v);
    TN_VALID = 1'b1;
    TN = v;
    tick();
    TN_VALID = 1'b0;
  endtask

  task automatic run_start(input logic mode, input logic tv, input logic [11:0] td,
                           output int lat, output logic samp_hi, output logic samp_done,
                           output logic done_after, output logic samp_after);
    START = 1'b1; MODE = mode; TN_VALID = tv; TN = td;
    tick();
    START = 1'b0; MODE = 1'b0; TN_VALID = 1'b0;
    lat = 0;
    samp_hi = 1'b0;
    do begin
      if (SAMPLE !== 1'b0) samp_hi = 1'b1;
      tick();
      lat++;
    end while (DONE !== 1'b1 && lat < 300);
    samp_done = SAMPLE;
    tick();
    done_after = DONE;
    samp_after = SAMPLE;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    tick();
    checks++; if (SAMPLE !== 1'b0) begin failures++; $display("FAIL reset_sample got=%b exp=0", SAMPLE); end
    checks++; if (DONE !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", DONE); end
    checks++; if (AVG_SD !== 12'd0) begin failures++; $display("FAIL reset_avg got=%0d exp=0", AVG_SD); end
    checks++; if (N !== 4'd0) begin failures++; $display("FAIL reset_n got=%0d exp=0", N); end
    RESET = 1'b0;
    tick();
    checks++; if (SAMPLE !== 1'b1) begin failures++; $display("FAIL reset_sample_rise got=%b exp=1", SAMPLE); end
  endtask

  task automatic test_empty();
    int lat; logic sh, sd, da, sa;
    run_start(1'b0, 1'b0, 12'd0, lat, sh, sd, da, sa);
    checks++; if (lat !== 1) begin failures++; $display("FAIL empty_latency got=%0d exp=1", lat); end
    checks++; if (AVG_SD !== 12'd0) begin failures++; $display("FAIL empty_avg got=%0d exp=0", AVG_SD); end
    checks++; if (N !== 4'd0) begin failures++; $display("FAIL empty_n got=%0d exp=0", N); end
    checks++; if (sd !== 1'b0) begin failures++; $display("FAIL empty_sample_at_done got=%b exp=0", sd); end
    checks++; if (da !== 1'b0 || sa !== 1'b1) begin failures++; $display("FAIL empty_after done=%b sample=%b exp done=0 sample=1", da, sa); end
  endtask

  task automatic test_mean_small();
    int lat; logic sh, sd, da, sa;
    do_reset();
    push(12'd100);
    checks++; if (N !== 4'd1) begin failures++; $display("FAIL small_n_first got=%0d exp=1", N); end
    push(12'd200);
    push(12'd300);
    checks++; if (N !== 4'd3) begin failures++; $display("FAIL small_n got=%0d exp=3", N); end
    run_start(1'b0, 1'b0, 12'd0, lat, sh, sd, da, sa);
    checks++; if (lat !== LAT_MEAN) begin failures++; $display("FAIL small_latency got=%0d exp=%0d", lat, LAT_MEAN); end
    checks++; if (AVG_SD !== 12'd200) begin failures++; $display("FAIL small_avg got=%0d exp=200", AVG_SD); end
    checks++; if (sh !== 1'b0) begin failures++; $display("FAIL small_sample_busy got=%b exp=0", sh); end
    checks++; if (da !== 1'b0 || sa !== 1'b1) begin failures++; $display("FAIL small_after done=%b sample=%b exp done=0 sample=1", da, sa); end
  endtask

  task automatic test_wrap();
    int lat; logic sh, sd, da, sa;
    do_reset();
    for (int v = 1; v <= 10; v++) push(12'(v));
    checks++; if (N !== 4'd8) begin failures++; $display("FAIL wrap_n got=%0d exp=8", N); end
    run_start(1'b0, 1'b0, 12'd0, lat, sh, sd, da, sa);
    checks++; if (AVG_SD !== 12'd6) begin failures++; $display("FAIL wrap_avg got=%0d exp=6", AVG_SD); end
    checks++; if (lat !== LAT_MEAN) begin failures++; $display("FAIL wrap_latency got=%0d exp=%0d", lat, LAT_MEAN); end
  endtask

  task automatic test_stddev();
    int lat; logic sh, sd, da, sa;
    logic [11:0] vals [8];
    vals = '{12'd2, 12'd4, 12'd4, 12'd4, 12'd5, 12'd5, 12'd7, 12'd9};
    do_reset();
    for (int i = 0; i < 8; i++) push(vals[i]);
    run_start(1'b0, 1'b0, 12'd0, lat, sh, sd, da, sa);
    checks++; if (AVG_SD !== 12'd5) begin failures++; $display("FAIL sd_window_mean got=%0d exp=5", AVG_SD); end
    run_start(1'b1, 1'b0, 12'd0, lat, sh, sd, da, sa);
    checks++; if (lat !== LAT_SD) begin failures++; $display("FAIL sd_latency got=%0d exp=%0d", lat, LAT_SD); end
    checks++; if (AVG_SD !== EXP_SD) begin failures++; $display("FAIL sd_value got=%0d exp=%0d", AVG_SD, EXP_SD); end
    checks++; if (sh !== 1'b0 || sd !== 1'b0) begin failures++; $display("FAIL sd_sample_busy got=%b/%b exp=0/0", sh, sd); end
  endtask

  task automatic test_reset_midway();
    int lat, pulses; logic sh, sd, da, sa;
    START = 1'b1; MODE = 1'b1;
    tick();
    START = 1'b0; MODE = 1'b0;
    pulses = 0;
    for (int i = 0; i < MID; i++) begin tick(); if (DONE === 1'b1) pulses++; end
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    checks++; if (AVG_SD !== 12'd0 || N !== 4'd0) begin failures++; $display("FAIL midrst_clear avg=%0d n=%0d exp 0/0", AVG_SD, N); end
    checks++; if (SAMPLE !== 1'b0 || DONE !== 1'b0) begin failures++; $display("FAIL midrst_outputs sample=%b done=%b exp 0/0", SAMPLE, DONE); end
    for (int i = 0; i < 70; i++) begin tick(); if (DONE === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d pulses exp=0", pulses); end
    push(12'd7);
    run_start(1'b0, 1'b0, 12'd0, lat, sh, sd, da, sa);
    checks++; if (AVG_SD !== 12'd7) begin failures++; $display("FAIL midrst_recover got=%0d exp=7", AVG_SD); end
  endtask

  task automatic test_busy_and_back_to_back();
    int lat, pulses; logic sh, sd, da, sa;
    do_reset();
    START = 1'b1; MODE = 1'b0; TN_VALID = 1'b1; TN = 12'd50;
    tick();
    lat = 0;
    for (int i = 0; i < 5; i++) begin
      TN_VALID = 1'b1; TN = 12'd999; START = (i == 2);
      tick();
      lat++;
    end
    TN_VALID = 1'b0; START = 1'b0;
    while (DONE !== 1'b1 && lat < 300) begin tick(); lat++; end
    checks++; if (lat !== LAT_MEAN) begin failures++; $display("FAIL busy_latency got=%0d exp=%0d", lat, LAT_MEAN); end
    checks++; if (AVG_SD !== 12'd50) begin failures++; $display("FAIL busy_avg got=%0d exp=50", AVG_SD); end
    checks++; if (N !== 4'd1) begin failures++; $display("FAIL busy_n got=%0d exp=1", N); end
    pulses = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (DONE === 1'b1) pulses++; end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL busy_start_ignored got=%0d pulses exp=0", pulses); end
    run_start(1'b0, 1'b0, 12'd0, lat, sh, sd, da, sa);
    run_start(1'b0, 1'b1, 12'd150, lat, sh, sd, da, sa);
    checks++; if (AVG_SD !== 12'd100 || N !== 4'd2) begin failures++; $display("FAIL b2b_avg got=%0d n=%0d exp 100/2", AVG_SD, N); end
    checks++; if (lat !== LAT_MEAN || sa !== 1'b1) begin failures++; $display("FAIL b2b_timing got lat=%0d sample=%b exp %0d/1", lat, sa, LAT_MEAN); end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_mean_small();
    test_wrap();
    test_stddev();
    test_reset_midway();
    test_busy_and_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
